// File: rtl/baby_kyber_decrypt_decode_if.sv
// Handshake and operand bundle for the Baby Kyber decrypt/decode block.
// Array index equals the power of x in the polynomial.
interface baby_kyber_decrypt_decode_if #(
    parameter int COEF_W = 32
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic signed [COEF_W-1:0] ct_u0 [4];
    logic signed [COEF_W-1:0] ct_u1 [4];
    logic signed [COEF_W-1:0] ct_v  [4];
    logic signed [COEF_W-1:0] sk_s0 [4];
    logic signed [COEF_W-1:0] sk_s1 [4];
    logic                     out_valid;
    logic                     out_ready;
    logic signed [COEF_W-1:0] w_out [4];
    logic [3:0]               msg_bits;

    modport master (
        output in_valid, ct_u0, ct_u1, ct_v, sk_s0, sk_s1, out_ready,
        input  in_ready, out_valid, w_out, msg_bits
    );

    modport slave (
        input  in_valid, ct_u0, ct_u1, ct_v, sk_s0, sk_s1, out_ready,
        output in_ready, out_valid, w_out, msg_bits
    );
endinterface

// File: rtl/baby_kyber_decrypt_decode.sv
// Baby Kyber receiver: w = v - (s0*u0 + s1*u1) in Z_q[x]/(x^4+1), then one
// message bit per coefficient. Single-lane MAC walks one key coefficient per
// cycle (8 cycles), followed by one reduce cycle.
module baby_kyber_decrypt_decode #(
    parameter int Q      = 17,
    parameter int COEF_W = 32
) (
    input logic clk,
    input logic rst,
    baby_kyber_decrypt_decode_if.slave bus
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StMac    = 2'd1;
    localparam logic [1:0] StReduce = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    localparam logic signed [COEF_W-1:0] QS  = COEF_W'(Q);
    localparam logic signed [COEF_W-1:0] QS3 = COEF_W'(3 * Q);

    // True modulo: result always in [0, Q-1], negatives map positive.
    function automatic logic signed [COEF_W-1:0] mod_q(input logic signed [COEF_W-1:0] a);
        logic signed [COEF_W-1:0] r;
        r = a % QS;
        if (r < 0) r = r + QS;
        return r;
    endfunction

    logic [1:0]               state_q;
    logic [2:0]               cnt_q;
    logic signed [COEF_W-1:0] acc_q [4];
    logic signed [COEF_W-1:0] u0_q  [4];
    logic signed [COEF_W-1:0] u1_q  [4];
    logic signed [COEF_W-1:0] s0_q  [4];
    logic signed [COEF_W-1:0] s1_q  [4];
    logic signed [COEF_W-1:0] w_q   [4];
    logic [3:0]               msg_q;
    logic                     out_valid_q;

    logic signed [COEF_W-1:0] acc_mac [4];
    logic signed [COEF_W-1:0] w_red   [4];
    logic [3:0]               msg_red;
    logic signed [COEF_W-1:0] s_c;
    logic signed [COEF_W-1:0] u_c;
    logic signed [COEF_W-1:0] prod;
    logic [1:0]               idx;
    logic [1:0]               ci;

    // One MAC step: subtract s_p[i]*u_p[k-i], sign flipped where the index wraps.
    always_comb begin
        ci   = cnt_q[1:0];
        s_c  = cnt_q[2] ? s1_q[ci] : s0_q[ci];
        idx  = '0;
        u_c  = '0;
        prod = '0;
        for (int k = 0; k < 4; k++) begin
            idx  = 2'(k) - ci;
            u_c  = cnt_q[2] ? u1_q[idx] : u0_q[idx];
            prod = s_c * u_c;
            acc_mac[k] = (2'(k) >= ci) ? acc_q[k] - prod : acc_q[k] + prod;
        end
    end

    // Final reduction and threshold decode: bit set iff Q/4 < w < 3Q/4.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_red[k]   = mod_q(acc_q[k]);
            msg_red[k] = ((w_red[k] <<< 2) > QS) && ((w_red[k] <<< 2) < QS3);
        end
    end

    // Control FSM plus capture, accumulator and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            msg_q       <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                acc_q[k] <= '0;
                u0_q[k]  <= '0;
                u1_q[k]  <= '0;
                s0_q[k]  <= '0;
                s1_q[k]  <= '0;
                w_q[k]   <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        for (int k = 0; k < 4; k++) begin
                            u0_q[k]  <= mod_q(bus.ct_u0[k]);
                            u1_q[k]  <= mod_q(bus.ct_u1[k]);
                            s0_q[k]  <= mod_q(bus.sk_s0[k]);
                            s1_q[k]  <= mod_q(bus.sk_s1[k]);
                            acc_q[k] <= mod_q(bus.ct_v[k]);
                        end
                        cnt_q   <= '0;
                        state_q <= StMac;
                    end
                end
                StMac: begin
                    acc_q <= acc_mac;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_q <= StReduce;
                end
                StReduce: begin
                    w_q         <= w_red;
                    msg_q       <= msg_red;
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                default: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.w_out     = w_q;
    assign bus.msg_bits  = msg_q;

endmodule

// File: tb/tb_baby_kyber_decrypt_decode.sv
// Directed bench for baby_kyber_decrypt_decode with hand-computed results.
module tb_baby_kyber_decrypt_decode;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   lat;
    logic signed [31:0] exp_w [4];

    baby_kyber_decrypt_decode_if #(.COEF_W(32)) bus ();

    baby_kyber_decrypt_decode #(.Q(17), .COEF_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_ops();
        bus.ct_u0 = '{0, 0, 0, 0};
        bus.ct_u1 = '{0, 0, 0, 0};
        bus.ct_v  = '{0, 0, 0, 0};
        bus.sk_s0 = '{0, 0, 0, 0};
        bus.sk_s1 = '{0, 0, 0, 0};
    endtask

    // Present operands for one edge; returns #1 after the acceptance edge.
    task automatic accept();
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Counts edges until out_valid is seen, bounded at 30.
    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        clear_ops();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset in_ready: got %0b expected 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset out_valid: got %0b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.msg_bits !== 4'b0000) begin
            errors++; $display("FAIL reset msg_bits: got %b expected 0000", bus.msg_bits);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.w_out[k] !== 32'sd0) begin
                errors++; $display("FAIL reset w_out[%0d]: got %0d expected 0", k, bus.w_out[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_plain_v();
        clear_ops();
        bus.ct_v = '{9, 9, 0, 0};
        exp_w = '{9, 9, 0, 0};
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL plain_v in_ready: got %0b expected 1", bus.in_ready);
        end
        accept();
        wait_out(lat);
        checks++;
        if (lat != 9) begin
            errors++; $display("FAIL plain_v latency: got %0d expected 9", lat);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.w_out[k] !== exp_w[k]) begin
                errors++;
                $display("FAIL plain_v w_out[%0d]: got %0d expected %0d", k, bus.w_out[k], exp_w[k]);
            end
        end
        checks++;
        if (bus.msg_bits !== 4'b0011) begin
            errors++; $display("FAIL plain_v msg_bits: got %b expected 0011", bus.msg_bits);
        end
        drain();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL plain_v handshake: got out_valid=%0b in_ready=%0b expected 0/1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_const_key();
        clear_ops();
        bus.sk_s0 = '{1, 0, 0, 0};
        bus.ct_u0 = '{1, 2, 3, 4};
        exp_w = '{16, 15, 14, 13};
        accept();
        wait_out(lat);
        checks++;
        if (lat != 9) begin
            errors++; $display("FAIL const_key latency: got %0d expected 9", lat);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.w_out[k] !== exp_w[k]) begin
                errors++;
                $display("FAIL const_key w_out[%0d]: got %0d expected %0d", k, bus.w_out[k], exp_w[k]);
            end
        end
        checks++;
        if (bus.msg_bits !== 4'b0000) begin
            errors++; $display("FAIL const_key msg_bits: got %b expected 0000", bus.msg_bits);
        end
        drain();
    endtask

    task automatic test_wrap();
        clear_ops();
        bus.sk_s0 = '{0, 1, 0, 0};
        bus.ct_u0 = '{0, 0, 0, 1};
        bus.ct_v  = '{8, 0, 0, 0};
        exp_w = '{9, 0, 0, 0};
        accept();
        wait_out(lat);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.w_out[k] !== exp_w[k]) begin
                errors++;
                $display("FAIL wrap w_out[%0d]: got %0d expected %0d", k, bus.w_out[k], exp_w[k]);
            end
        end
        checks++;
        if (bus.msg_bits !== 4'b0001) begin
            errors++; $display("FAIL wrap msg_bits: got %b expected 0001", bus.msg_bits);
        end
        drain();
    endtask

    task automatic test_normalise();
        clear_ops();
        bus.ct_v = '{-8, 34, 12, 13};
        exp_w = '{9, 0, 12, 13};
        accept();
        wait_out(lat);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.w_out[k] !== exp_w[k]) begin
                errors++;
                $display("FAIL normalise w_out[%0d]: got %0d expected %0d", k, bus.w_out[k], exp_w[k]);
            end
        end
        checks++;
        if (bus.msg_bits !== 4'b0101) begin
            errors++; $display("FAIL normalise msg_bits: got %b expected 0101", bus.msg_bits);
        end
        drain();
    endtask

    // Both key pairs active: 2*x + 6*x^4 = [-6,2,0,0]; v=[0,0,5,0] -> w=[6,15,5,0].
    task automatic test_two_pairs();
        clear_ops();
        bus.sk_s0 = '{2, 0, 0, 0};
        bus.ct_u0 = '{0, 1, 0, 0};
        bus.sk_s1 = '{0, 0, 2, 0};
        bus.ct_u1 = '{0, 0, 3, 0};
        bus.ct_v  = '{0, 0, 5, 0};
        exp_w = '{6, 15, 5, 0};
        accept();
        wait_out(lat);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.w_out[k] !== exp_w[k]) begin
                errors++;
                $display("FAIL two_pairs w_out[%0d]: got %0d expected %0d", k, bus.w_out[k], exp_w[k]);
            end
        end
        checks++;
        if (bus.msg_bits !== 4'b0101) begin
            errors++; $display("FAIL two_pairs msg_bits: got %b expected 0101", bus.msg_bits);
        end
        drain();
    endtask

    task automatic test_backpressure();
        clear_ops();
        bus.ct_v = '{9, 9, 0, 0};
        accept();
        wait_out(lat);
        // New operands offered while the result is held.
        clear_ops();
        bus.sk_s0 = '{1, 0, 0, 0};
        bus.ct_u0 = '{1, 2, 3, 4};
        bus.in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.msg_bits !== 4'b0011 ||
                bus.w_out[0] !== 32'sd9 || bus.w_out[1] !== 32'sd9 || bus.w_out[2] !== 32'sd0) begin
                errors++;
                $display("FAIL backpressure hold: got out_valid=%0b in_ready=%0b msg=%b w0=%0d w1=%0d expected 1/0/0011/9/9",
                         bus.out_valid, bus.in_ready, bus.msg_bits, bus.w_out[0], bus.w_out[1]);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure release: got out_valid=%0b in_ready=%0b expected 0/1",
                     bus.out_valid, bus.in_ready);
        end
        accept();
        wait_out(lat);
        checks++;
        if (lat != 9) begin
            errors++; $display("FAIL backpressure latency: got %0d expected 9", lat);
        end
        exp_w = '{16, 15, 14, 13};
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.w_out[k] !== exp_w[k]) begin
                errors++;
                $display("FAIL backpressure w_out[%0d]: got %0d expected %0d", k, bus.w_out[k], exp_w[k]);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid_mac();
        clear_ops();
        bus.sk_s0 = '{1, 0, 0, 0};
        bus.ct_u0 = '{1, 2, 3, 4};
        accept();
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.msg_bits !== 4'b0000) begin
            errors++;
            $display("FAIL mid_mac_reset ctrl: got out_valid=%0b in_ready=%0b msg=%b expected 0/1/0000",
                     bus.out_valid, bus.in_ready, bus.msg_bits);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.w_out[k] !== 32'sd0) begin
                errors++; $display("FAIL mid_mac_reset w_out[%0d]: got %0d expected 0", k, bus.w_out[k]);
            end
        end
        clear_ops();
        bus.sk_s0 = '{0, 1, 0, 0};
        bus.ct_u0 = '{0, 0, 0, 1};
        bus.ct_v  = '{8, 0, 0, 0};
        exp_w = '{9, 0, 0, 0};
        accept();
        wait_out(lat);
        checks++;
        if (lat != 9) begin
            errors++; $display("FAIL post_reset latency: got %0d expected 9", lat);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.w_out[k] !== exp_w[k]) begin
                errors++;
                $display("FAIL post_reset w_out[%0d]: got %0d expected %0d", k, bus.w_out[k], exp_w[k]);
            end
        end
        drain();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        clear_ops();
        test_reset();
        test_plain_v();
        test_const_key();
        test_wrap();
        test_normalise();
        test_two_pairs();
        test_backpressure();
        test_reset_mid_mac();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
